// File: rtl/nios_led_out_pkg.sv
// Shared definitions for the nios_led_out PIO block.
// Holds the Avalon-MM register word offsets, the pulse engine state
// encoding and a small helper used to decode the slave write strobe.
package nios_led_out_pkg;

    // Register word offsets on the slave port
    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_PULSE_LEN = 3'd1;
    localparam logic [2:0] ADDR_PULSE     = 3'd2;
    localparam logic [2:0] ADDR_OUTSET    = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

    // Pulse engine states
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pulse_state_e;

    // A slave write happens when the port is selected and write_n is low
    function automatic logic slave_write(input logic chipselect, input logic write_n);
        return chipselect && !write_n;
    endfunction

endpackage

// File: rtl/nios_led_pulse_timer.sv
// One-shot pulse engine for the LED PIO.
// A trigger with a nonzero length and nonzero mask loads the counter and
// drives the mask for exactly 'len' cycles. A trigger with a zero length or
// zero mask aborts a running pulse and is ignored when idle. Retriggering
// while running reloads the counter and replaces the mask, and takes
// priority over the expiry that would otherwise happen on the same edge.
module nios_led_pulse_timer
    import nios_led_out_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int PULSE_W = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               trigger,
    input  logic [PULSE_W-1:0] len,
    input  logic [WIDTH-1:0]   mask_in,
    output logic [WIDTH-1:0]   pulse_mask
);

    localparam logic [PULSE_W-1:0] CNT_ONE = PULSE_W'(1);

    pulse_state_e       state;
    logic [PULSE_W-1:0] counter;
    logic               start_ok;

    // A trigger only starts a pulse when both length and mask are nonzero
    assign start_ok = (len != '0) && (mask_in != '0);

    // Pulse state machine: counter, mask and state updated together
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            counter    <= '0;
            pulse_mask <= '0;
        end else if (trigger) begin
            if (start_ok) begin
                state      <= RUN;
                counter    <= len;
                pulse_mask <= mask_in;
            end else if (state == RUN) begin
                state      <= IDLE;
                counter    <= '0;
                pulse_mask <= '0;
            end
        end else if (state == RUN) begin
            if (counter == CNT_ONE) begin
                // Last active cycle: the count never goes below one
                state      <= IDLE;
                counter    <= '0;
                pulse_mask <= '0;
            end else begin
                counter <= counter - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/nios_led_out.sv
// Avalon-MM slave output PIO driving board LEDs.
// Registers: DATA (RW), PULSE_LEN (RW), PULSE (trigger / active mask),
// OUTSET and OUTCLEAR (atomic bit set/clear of DATA). Reads are registered
// with one cycle of latency and have no side effects. out_port is the
// registered OR of DATA and the active pulse mask.
// Build option: define NIOS_LED_OUT_INVERT_EN to drive out_port inverted
// for active-low LEDs (reset value inverted too; register reads unaffected).
module nios_led_out
    import nios_led_out_pkg::*;
#(
    parameter int          WIDTH       = 4,
    parameter int          PULSE_W     = 24,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [WIDTH-1:0] DATA_RESET = RESET_VALUE[WIDTH-1:0];
`ifdef NIOS_LED_OUT_INVERT_EN
    localparam logic [WIDTH-1:0] OUT_RESET  = ~DATA_RESET;
`else
    localparam logic [WIDTH-1:0] OUT_RESET  = DATA_RESET;
`endif

    logic               wr_en;
    logic [WIDTH-1:0]   wdata_bits;
    logic [WIDTH-1:0]   data;
    logic [PULSE_W-1:0] pulse_len;
    logic [WIDTH-1:0]   pulse_mask;
    logic               pulse_trigger;
    logic [31:0]        read_mux;
    logic [WIDTH-1:0]   out_value;
    logic               unused_wdata;

    assign wr_en         = slave_write(chipselect, write_n);
    assign wdata_bits    = writedata[WIDTH-1:0];
    assign pulse_trigger = wr_en && (address == ADDR_PULSE);

    // Upper write-data bits beyond the register widths are intentionally dropped
    assign unused_wdata = ^writedata;

    // DATA register: direct write plus atomic set and clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= DATA_RESET;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:     data <= wdata_bits;
                ADDR_OUTSET:   data <= data | wdata_bits;
                ADDR_OUTCLEAR: data <= data & ~wdata_bits;
                default:       data <= data;
            endcase
        end
    end

    // PULSE_LEN register; a running pulse keeps its own loaded count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_len <= '0;
        end else if (wr_en && (address == ADDR_PULSE_LEN)) begin
            pulse_len <= writedata[PULSE_W-1:0];
        end
    end

    // One-shot pulse engine
    nios_led_pulse_timer #(
        .WIDTH   (WIDTH),
        .PULSE_W (PULSE_W)
    ) u_pulse_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .trigger    (pulse_trigger),
        .len        (pulse_len),
        .mask_in    (wdata_bits),
        .pulse_mask (pulse_mask)
    );

    // Read mux: logical register values, zero-extended, reserved reads 0
    // NOTE: read_mux gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA:      read_mux = 32'(data);
            ADDR_PULSE_LEN: read_mux = 32'(pulse_len);
            ADDR_PULSE:     read_mux = 32'(pulse_mask);
            default:        read_mux = '0;
        endcase
    end

    // Registered read data, sampled every cycle regardless of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= read_mux;
        end
    end

`ifdef NIOS_LED_OUT_INVERT_EN
    assign out_value = ~(data | pulse_mask);
`else
    assign out_value = data | pulse_mask;
`endif

    // Registered LED drive, one cycle behind the register state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port <= OUT_RESET;
        end else begin
            out_port <= out_value;
        end
    end

endmodule

// File: tb/tb_nios_led_out.sv
// Self-checking bench for nios_led_out (WIDTH=4, PULSE_W=24, RESET_VALUE=0xA).
// The reference model tracks the pulse as an absolute end cycle: a pulse with
// mask m triggered at edge t is visible in the PULSE register after edges
// t .. t+len-1. Directed scenarios run first, then randomized traffic.
module tb_nios_led_out;

    localparam int          WIDTH   = 4;
    localparam int          PULSE_W = 24;
    localparam logic [31:0] RST_VAL = 32'hA;
`ifdef NIOS_LED_OUT_INVERT_EN
    localparam logic [3:0]  INV     = 4'hF;
`else
    localparam logic [3:0]  INV     = 4'h0;
`endif

    logic             clk;
    logic             reset_n;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] out_port;

    nios_led_out #(
        .WIDTH       (WIDTH),
        .PULSE_W     (PULSE_W),
        .RESET_VALUE (RST_VAL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         cyc = 0;
    logic [3:0] m_data;
    logic [23:0] m_plen;
    logic [3:0] m_pmask;
    int         m_pend;
    logic [3:0] seen_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] active_mask();
        return (cyc < m_pend) ? m_pmask : 4'h0;
    endfunction

    task automatic model_reset();
        m_data  = RST_VAL[3:0];
        m_plen  = '0;
        m_pmask = '0;
        m_pend  = cyc;
    endtask

    // One bus cycle: drive at negedge, model the edge, check at next negedge
    task automatic step(input logic [2:0] a, input logic cs, input logic wn,
                        input logic [31:0] wd, input string tag);
        logic [3:0]  cur;
        logic [31:0] exp_rd;
        logic [3:0]  exp_out;
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        cur = active_mask();
        case (a)
            3'd0:    exp_rd = {28'h0, m_data};
            3'd1:    exp_rd = {8'h0, m_plen};
            3'd2:    exp_rd = {28'h0, cur};
            default: exp_rd = 32'h0;
        endcase
        exp_out = (m_data | cur) ^ INV;
        @(posedge clk);
        cyc++;
        if (cs && !wn) begin
            case (a)
                3'd0: m_data = wd[3:0];
                3'd1: m_plen = wd[23:0];
                3'd2: begin
                    if (m_plen != 0 && wd[3:0] != 0) begin
                        m_pmask = wd[3:0];
                        m_pend  = cyc + int'(m_plen);
                    end else if (cur != 0) begin
                        m_pend = cyc;
                    end
                end
                3'd4: m_data = m_data | wd[3:0];
                3'd5: m_data = m_data & ~wd[3:0];
                default: ;
            endcase
        end
        @(negedge clk);
        check({tag, "_rd"}, readdata, exp_rd);
        check({tag, "_out"}, {28'h0, out_port}, {28'h0, exp_out});
        seen_out = out_port ^ INV;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd, input string tag);
        step(a, 1'b1, 1'b0, wd, tag);
    endtask

    task automatic rd(input logic [2:0] a, input string tag);
        step(a, 1'b1, 1'b1, $urandom, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        model_reset();

        // Reset state
        #12;
        check("reset_out", {28'h0, out_port}, {28'h0, RST_VAL[3:0] ^ INV});
        check("reset_rd", readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(3'd0, "rd_data_pre");
        rd(3'd0, "rd_data_reset");

        // Set / clear
        wr(3'd0, 32'hFFFF_FFF3, "set_data");
        wr(3'd4, 32'h8, "outset");
        wr(3'd5, 32'h1, "outclear");
        rd(3'd0, "rd_after_sc");
        rd(3'd0, "rd_after_sc2");
        check("sc_final_data", readdata, 32'hA);

        // Basic pulse: exactly 5 cycles
        wr(3'd0, 32'h0, "clr_data");
        wr(3'd1, 32'h5, "plen5");
        wr(3'd2, 32'h4, "trig4");
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            rd(3'd2, "pulse5");
            if (seen_out == 4'h4) cnt++;
        end
        check("pulse5_len", cnt, 5);

        // Retrigger mid-pulse with a new mask
        wr(3'd1, 32'd10, "plen10");
        wr(3'd2, 32'h4, "trig10");
        for (int i = 0; i < 8; i++) rd(3'd2, "run10");
        wr(3'd2, 32'h2, "retrig2");
        cnt = 0;
        for (int i = 0; i < 14; i++) begin
            rd(3'd2, "retrig_run");
            if (seen_out == 4'h2) cnt++;
        end
        check("retrig_len", cnt, 10);

        // Retrigger on the expiry edge wins
        wr(3'd1, 32'd3, "plen3");
        wr(3'd2, 32'h1, "trig3");
        rd(3'd2, "run3a");
        rd(3'd2, "run3b");
        wr(3'd2, 32'h8, "retrig_exp");
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            rd(3'd2, "exp_run");
            if (seen_out == 4'h8) cnt++;
        end
        check("retrig_exp_len", cnt, 3);

        // Abort: zero length, then zero mask
        wr(3'd1, 32'd6, "plen6");
        wr(3'd2, 32'h2, "trig6");
        rd(3'd2, "run6");
        wr(3'd1, 32'd0, "plen0");
        wr(3'd2, 32'h1, "abort_len0");
        rd(3'd2, "aborted_a");
        rd(3'd2, "aborted_b");
        wr(3'd1, 32'd6, "plen6b");
        wr(3'd2, 32'h2, "trig6b");
        wr(3'd2, 32'h0, "abort_mask0");
        rd(3'd2, "aborted_c");
        rd(3'd2, "aborted_d");

        // Reset mid-pulse
        wr(3'd0, 32'h1, "data1");
        wr(3'd1, 32'd20, "plen20");
        wr(3'd2, 32'hF, "trig20");
        rd(3'd2, "run20a");
        rd(3'd2, "run20b");
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_out", {28'h0, out_port}, {28'h0, RST_VAL[3:0] ^ INV});
        check("midrst_rd", readdata, 32'h0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            rd(3'd2, "post_rst");
            if (seen_out != RST_VAL[3:0]) cnt++;
        end
        check("post_rst_no_pulse", cnt, 0);

        // Reserved addresses and deselected writes
        wr(3'd3, 32'hFFFF_FFFF, "wr_res3");
        wr(3'd6, 32'hFFFF_FFFF, "wr_res6");
        wr(3'd7, 32'hFFFF_FFFF, "wr_res7");
        step(3'd0, 1'b0, 1'b0, 32'h5, "wr_nocs");
        step(3'd1, 1'b0, 1'b0, 32'h7, "wr_nocs_len");
        step(3'd2, 1'b0, 1'b0, 32'hF, "wr_nocs_pulse");
        rd(3'd3, "rd_res3");
        rd(3'd6, "rd_res6");
        rd(3'd7, "rd_res7");
        rd(3'd4, "rd_outset");
        rd(3'd0, "rd_data_res");
        rd(3'd1, "rd_len_res");
        step(3'd0, 1'b0, 1'b1, 32'h0, "rd_nocs");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  a;
            logic [31:0] wd;
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd1) wd = {$urandom_range(0, 255), 8'h0} | 32'($urandom_range(0, 12));
            step(a, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, wd, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
